// File: rtl/display_pkg.sv
// Shared constants, command encoding and the hex-to-segment decoder for the
// digit entry display.
package display_pkg;

    // Width of one stored digit
    localparam int DIGIT_W = 4;

    // Segment pattern with every segment dark (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Pushbutton positions within key_n
    localparam int KEY_WRITE = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_CLEAR = 3;

    // Command selected in a cycle after priority resolution
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_CLEAR = 3'd4
    } cmd_e;

    // Active-low seven-segment glyph, bit 0 = segment a, full hex set
    function automatic logic [6:0] hex_to_seg(input logic [DIGIT_W-1:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, symmetric debounce counter and a
// single-cycle pulse on every accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_L,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESSED = 1'b1;

    logic             sync_meta_reg;
    logic             sync_out_reg;
    logic [0:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             press_reg;
    logic             opposing;

    // Two-flop synchroniser; resets to the released level
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync_meta_reg <= 1'b1;
            sync_out_reg  <= 1'b1;
        end else begin
            sync_meta_reg <= key_n;
            sync_out_reg  <= sync_meta_reg;
        end
    end

    // A sample "opposes" the debounced state when it points the other way
    assign opposing = (state_reg == ST_IDLE) ? ~sync_out_reg : sync_out_reg;

    // Count consecutive opposing samples; flip state on the last one and
    // pulse only on the idle-to-pressed transition
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            press_reg <= 1'b0;
            if (opposing) begin
                if (count_reg == CNT_LAST) begin
                    state_reg <= ~state_reg;
                    count_reg <= '0;
                    press_reg <= (state_reg == ST_IDLE);
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end else begin
                count_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/digit_entry_display.sv
// Hex digit entry with a cursor, four debounced keys and registered
// seven-segment outputs. Optional cursor blink: define DIGIT_ENTRY_BLINK_EN.
module digit_entry_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS        = 8,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_PERIOD = 2**22
) (
    input  logic                          clock,
    input  logic                          reset_L,
    input  logic [3:0]                    key_n,
    input  logic [DIGIT_W-1:0]            data_in,
    input  logic [NUM_DIGITS-1:0]         enable_mask,
    output logic [NUM_DIGITS*7-1:0]       hex_out,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor
);

    localparam int CUR_W = $clog2(NUM_DIGITS);
    localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NUM_DIGITS - 1);

    // Elaboration-time guard on the legal parameter ranges
    if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("NUM_DIGITS out of range");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (BLINK_HALF_PERIOD < 2) begin : g_bad_blink
        $error("BLINK_HALF_PERIOD must be at least 2");
    end

    logic [3:0]         press;
    cmd_e               cmd;
    logic [DIGIT_W-1:0] digits_reg [NUM_DIGITS];
    logic [CUR_W-1:0]   cursor_reg;
    logic [CUR_W-1:0]   cursor_inc;
    logic [CUR_W-1:0]   cursor_dec;
    logic               blink_off;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clock   (clock),
            .reset_L (reset_L),
            .key_n   (key_n[gi]),
            .press   (press[gi])
        );
    end

    // Single winner per cycle: clear > write > left > right
    always_comb begin
        cmd = CMD_NONE;
        if (press[KEY_CLEAR]) begin
            cmd = CMD_CLEAR;
        end else if (press[KEY_WRITE]) begin
            cmd = CMD_WRITE;
        end else if (press[KEY_LEFT]) begin
            cmd = CMD_LEFT;
        end else if (press[KEY_RIGHT]) begin
            cmd = CMD_RIGHT;
        end
    end

    // Explicit wrap so non-power-of-two digit counts behave
    assign cursor_inc = (cursor_reg == CUR_LAST) ? '0 : cursor_reg + 1'b1;
    assign cursor_dec = (cursor_reg == '0) ? CUR_LAST : cursor_reg - 1'b1;

    // Cursor movement for every command
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cursor_reg <= '0;
        end else begin
            case (cmd)
                CMD_CLEAR: cursor_reg <= '0;
                CMD_WRITE: cursor_reg <= cursor_inc;
                CMD_LEFT:  cursor_reg <= cursor_inc;
                CMD_RIGHT: cursor_reg <= cursor_dec;
                default:   cursor_reg <= cursor_reg;
            endcase
        end
    end

    // Digit storage: clear zeroes everything, write hits only the cursor digit
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cmd == CMD_CLEAR) begin
                    digits_reg[i] <= '0;
                end else if (cmd == CMD_WRITE && cursor_reg == CUR_W'(i)) begin
                    digits_reg[i] <= data_in;
                end
            end
        end
    end

`ifdef DIGIT_ENTRY_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF_PERIOD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_off_reg;

    // Free-running half-phase counter; any command restarts it visible
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else if (cmd != CMD_NONE) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= ~blink_off_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign blink_off = blink_off_reg;
`else
    assign blink_off = 1'b0;
`endif

    // Registered segment drive: blank when disabled or blinked off
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            hex_out <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!enable_mask[i] || (blink_off && cursor_reg == CUR_W'(i))) begin
                    hex_out[i*7 +: 7] <= SEG_BLANK;
                end else begin
                    hex_out[i*7 +: 7] <= hex_to_seg(digits_reg[i]);
                end
            end
        end
    end

    assign cursor = cursor_reg;

endmodule

// File: tb/tb_digit_entry_display.sv
// Directed bench for digit_entry_display with a scoreboard of expected
// display/cursor states. Blink checks follow DIGIT_ENTRY_BLINK_EN.
module tb_digit_entry_display;

    localparam int N   = 8;
    localparam int DEB = 4;
    localparam int BHP = 8;

    logic           clock;
    logic           reset_L;
    logic [3:0]     key_n;
    logic [3:0]     data_in;
    logic [N-1:0]   enable_mask;
    logic [N*7-1:0] hex_out;
    logic [2:0]     cursor;

    digit_entry_display #(
        .NUM_DIGITS        (N),
        .DEBOUNCE_CYCLES   (DEB),
        .BLINK_HALF_PERIOD (BHP)
    ) dut (
        .clock       (clock),
        .reset_L     (reset_L),
        .key_n       (key_n),
        .data_in     (data_in),
        .enable_mask (enable_mask),
        .hex_out     (hex_out),
        .cursor      (cursor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        tag;
        logic [N*7-1:0] hex;
        logic [2:0]   cur;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    int   m_dig [N];
    int   m_cur;

    function automatic logic [6:0] seg_ref(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [N*7-1:0] model_hex();
        logic [N*7-1:0] h;
        for (int i = 0; i < N; i++) begin
            h[i*7 +: 7] = enable_mask[i] ? seg_ref(m_dig[i]) : 7'h7F;
        end
        return h;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_raw(input string tag, input logic [N*7-1:0] h, input logic [2:0] c);
        exp_t e;
        e.tag = tag;
        e.hex = h;
        e.cur = c;
        sb.push_back(e);
    endtask

    task automatic push_model(input string tag);
        push_raw(tag, model_hex(), 3'(m_cur));
    endtask

    // Pop the oldest expectation and compare against the live outputs
    task automatic check_next();
        exp_t           e;
        logic [N*7-1:0] m;
        checks++;
        assert (sb.size() > 0) passes++;
        else $error("FAIL scoreboard_empty observed=0 entries expected>=1");
        if (sb.size() > 0) begin
            e = sb.pop_front();
            m = '1;
`ifdef DIGIT_ENTRY_BLINK_EN
            m[e.cur*7 +: 7] = 7'h00;
`endif
            checks++;
            assert ((hex_out & m) === (e.hex & m)) passes++;
            else $error("FAIL %s hex_out observed=%h expected=%h", e.tag, hex_out & m, e.hex & m);
            checks++;
            assert (cursor === e.cur) passes++;
            else $error("FAIL %s cursor observed=%0d expected=%0d", e.tag, cursor, e.cur);
        end
    endtask

    // Press a key combination, hold, release and let everything settle
    task automatic press(input logic [3:0] keys, input logic [3:0] d, input string tag);
        data_in = d;
        key_n   = ~keys;
        tick(10);
        key_n   = 4'hF;
        tick(12);
        if (keys[3]) begin
            for (int i = 0; i < N; i++) m_dig[i] = 0;
            m_cur = 0;
        end else if (keys[0]) begin
            m_dig[m_cur] = int'(d);
            m_cur = (m_cur + 1) % N;
        end else if (keys[1]) begin
            m_cur = (m_cur + 1) % N;
        end else if (keys[2]) begin
            m_cur = (m_cur + N - 1) % N;
        end
        push_model(tag);
        check_next();
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 0;
        m_cur = 0;
    endtask

    initial begin
        int glitch [9];
        int trans [$];
        logic blank_now;
        logic blank_prev;
        logic ok;

        glitch = '{0, 0, 0, 1, 0, 1, 0, 0, 1};
        reset_L     = 1'b1;
        key_n       = 4'hF;
        data_in     = 4'h0;
        enable_mask = 8'hFF;
        model_reset();

        // Asynchronous reset takes effect without a clock edge
        #1 reset_L = 1'b0;
        #2;
        push_raw("reset_async", {N{7'h7F}}, 3'd0);
        check_next();

        tick(2);
        reset_L = 1'b1;
        tick(1);
        push_model("reset_release");
        check_next();

        // Short lows and glitches must not be accepted
        for (int i = 0; i < 9; i++) begin
            key_n[0] = glitch[i][0];
            tick(1);
        end
        key_n = 4'hF;
        tick(8);
        push_model("glitch_no_write");
        check_next();

        press(4'b0001, 4'hA, "write_A");

        press(4'b1000, 4'h0, "clear_1");
        for (int v = 1; v <= 8; v++) begin
            press(4'b0001, 4'(v), $sformatf("write_%0d", v));
        end
        press(4'b0001, 4'hF, "write_F_wrap");

        press(4'b0100, 4'h0, "right_to_0");
        press(4'b0100, 4'h0, "right_wrap_7");
        press(4'b0010, 4'h0, "left_wrap_0");
        press(4'b0010, 4'h0, "left_to_1");

        press(4'b1001, 4'h5, "clear_beats_write");

        press(4'b0001, 4'h3, "write_3");
        press(4'b0001, 4'hC, "write_C");
        press(4'b0001, 4'hD, "write_d");
        press(4'b0001, 4'hE, "write_E");
        press(4'b0001, 4'h9, "write_9");

        enable_mask = 8'h0F;
        tick(1);
        push_model("mask_0F");
        check_next();
        enable_mask = 8'hFF;
        tick(1);
        push_model("mask_FF");
        check_next();

        // Cursor digit behaviour over time
        trans.delete();
        blank_prev = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            blank_now = (hex_out[m_cur*7 +: 7] == 7'h7F);
            if (i > 0 && blank_now != blank_prev) trans.push_back(i);
            blank_prev = blank_now;
        end
`ifdef DIGIT_ENTRY_BLINK_EN
        ok = (trans.size() >= 4);
        for (int k = 1; k < trans.size(); k++) begin
            if (trans[k] - trans[k-1] != BHP) ok = 1'b0;
        end
        checks++;
        assert (ok) passes++;
        else $error("FAIL blink_period observed_transitions=%0d expected_spacing=%0d", trans.size(), BHP);
`else
        checks++;
        assert (trans.size() == 0 && !blank_now) passes++;
        else $error("FAIL no_blink observed_transitions=%0d expected=0", trans.size());
`endif

        // Reset mid-debounce with the key released during reset
        data_in = 4'h6;
        key_n[0] = 1'b0;
        tick(4);
        reset_L = 1'b0;
        key_n = 4'hF;
        tick(2);
        reset_L = 1'b1;
        tick(20);
        model_reset();
        push_model("reset_mid_debounce");
        check_next();

        // Key held through reset needs a full debounce afterwards
        key_n[0] = 1'b0;
        tick(4);
        reset_L = 1'b0;
        tick(2);
        reset_L = 1'b1;
        tick(4);
        push_model("held_not_yet");
        check_next();
        tick(8);
        key_n = 4'hF;
        tick(12);
        m_dig[0] = 6;
        m_cur = 1;
        push_model("held_full_debounce");
        check_next();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
